// File: rtl/demux1a2_2b_pkg.sv
// demux_pkg: shared defaults and constants for the 1:2 valid/data demultiplexer.
//   DATA_W / DEPTH : default word width and per-lane FIFO depth
//   LANE0 / LANE1  : lane index encodings used by the selector
//   PTR_W / CNT_W  : pointer and occupancy widths derived from DEPTH
package demux_pkg;

    localparam int unsigned DATA_W = 2;
    localparam int unsigned DEPTH  = 4;

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

endpackage : demux_pkg

// File: rtl/demux1a2_2b_fifo_lane.sv
// fifo_lane: show-ahead synchronous FIFO for one demux lane.
// The head word is held in a register so data_o is valid the cycle after the
// word is written into an empty lane, and reads 0 whenever the lane is empty.
// Ports:
//   clk, reset_L : clock, synchronous active-low reset
//   push_i       : write data_i (ignored while full)
//   data_i       : word to write
//   pop_i        : remove head word (ignored while empty)
//   data_o       : head word, 0 when empty
//   empty_o      : no words stored
//   full_o       : DEPTH words stored
module fifo_lane
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = demux_pkg::DATA_W,
    parameter int unsigned DEPTH  = demux_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [DATA_W-1:0] head_q,   head_d;
    logic              empty_q,  empty_d;
    logic              full_q,   full_d;
    logic              do_push;
    logic              do_pop;

    // Qualify requests against current occupancy
    assign do_push = push_i & (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop_i  & (count_q != CNT_W'(0));

    // Next-state: pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        empty_d  = empty_q;
        full_d   = full_q;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

        // New head comes from the word being written only when the lane
        // drains to (or starts from) nothing older than this push.
        if (count_d == CNT_W'(0)) begin
            head_d = '0;
        end else if (do_push && (rd_ptr_d == wr_ptr_q)) begin
            head_d = data_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end

        empty_d = (count_d == CNT_W'(0));
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    // Storage array; contents need no reset since occupancy is tracked
    always_ff @(posedge clk) begin
        if (reset_L && do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Control and head registers
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    assign data_o  = head_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule : fifo_lane

// File: rtl/demux1a2_2b.sv
// demux1a2_2b: splits one interleaved valid/data stream into two lanes, each
// buffered by a show-ahead FIFO drained independently by its consumer.
// By default an internal round-robin selector (starting at lane 0) picks the
// destination lane and advances only on an accepted word. With the macro
// DEMUX_SEL_EXT_EN defined, input sel_in chooses the lane instead and no
// selector register exists.
// Ports:
//   clk, reset_L          : clock, synchronous active-low reset
//   sel_in                : lane select (DEMUX_SEL_EXT_EN builds only)
//   data_in, valid_in     : interleaved input word and its qualifier
//   ready_out             : selected lane can take a word (combinational)
//   pop0, pop1            : lane consumers take their head word
//   data_out0/1           : lane head words, 0 when empty
//   valid_out0/1          : lane FIFO not empty
//   full0/1               : lane FIFO holds DEPTH words
module demux1a2_2b #(
    parameter int unsigned DATA_W = demux_pkg::DATA_W,
    parameter int unsigned DEPTH  = demux_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset_L,
`ifdef DEMUX_SEL_EXT_EN
    input  logic              sel_in,
`endif
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              pop0,
    input  logic              pop1,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid_out0,
    output logic              valid_out1,
    output logic              full0,
    output logic              full1
);

    import demux_pkg::*;

    logic sel;
    logic accept;
    logic push0;
    logic push1;
    logic empty0;
    logic empty1;

`ifdef DEMUX_SEL_EXT_EN
    assign sel = sel_in;
`else
    logic sel_q, sel_d;

    // Round-robin pointer: holds through idle and stalled cycles
    always_comb begin
        sel_d = sel_q;
        if (accept) begin
            sel_d = ~sel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            sel_q <= LANE0;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign sel = sel_q;
`endif

    // Only the selected lane's occupancy throttles upstream
    assign ready_out = (sel == LANE1) ? ~full1 : ~full0;
    assign accept    = valid_in & ready_out;
    assign push0     = accept & (sel == LANE0);
    assign push1     = accept & (sel == LANE1);

    fifo_lane #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_lane0 (
        .clk     (clk),
        .reset_L (reset_L),
        .push_i  (push0),
        .data_i  (data_in),
        .pop_i   (pop0),
        .data_o  (data_out0),
        .empty_o (empty0),
        .full_o  (full0)
    );

    fifo_lane #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_lane1 (
        .clk     (clk),
        .reset_L (reset_L),
        .push_i  (push1),
        .data_i  (data_in),
        .pop_i   (pop1),
        .data_o  (data_out1),
        .empty_o (empty1),
        .full_o  (full1)
    );

    assign valid_out0 = ~empty0;
    assign valid_out1 = ~empty1;

endmodule : demux1a2_2b

// File: tb/tb_demux1a2_2b.sv
// Testbench for demux1a2_2b: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model of the two lanes.
module tb_demux1a2_2b;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [1:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       pop0, pop1;
    logic [1:0] data_out0, data_out1;
    logic       valid_out0, valid_out1;
    logic       full0, full1;
`ifdef DEMUX_SEL_EXT_EN
    logic       sel_in = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one queue per lane plus the lane the next word goes to
    logic [1:0] q0 [$];
    logic [1:0] q1 [$];
    bit         m_sel = 1'b0;

    always #5 clk = ~clk;

    demux1a2_2b dut (
        .clk        (clk),
        .reset_L    (reset_L),
`ifdef DEMUX_SEL_EXT_EN
        .sel_in     (sel_in),
`endif
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .pop0       (pop0),
        .pop1       (pop1),
        .data_out0  (data_out0),
        .data_out1  (data_out1),
        .valid_out0 (valid_out0),
        .valid_out1 (valid_out1),
        .full0      (full0),
        .full1      (full1)
    );

    function automatic bit cur_sel();
`ifdef DEMUX_SEL_EXT_EN
        return sel_in;
`else
        return m_sel;
`endif
    endfunction

    // {ready, v0, d0, f0, v1, d1, f1} predicted from the lane queues
    function automatic logic [8:0] exp_vec();
        logic       r;
        logic [1:0] h0, h1;
        r  = cur_sel() ? (q1.size() != DEPTH) : (q0.size() != DEPTH);
        h0 = (q0.size() != 0) ? q0[0] : 2'b00;
        h1 = (q1.size() != 0) ? q1[0] : 2'b00;
        return {r, q0.size() != 0, h0, q0.size() == DEPTH,
                   q1.size() != 0, h1, q1.size() == DEPTH};
    endfunction

    function automatic logic [8:0] obs_vec();
        return {ready_out, valid_out0, data_out0, full0,
                valid_out1, data_out1, full1};
    endfunction

    // Set inputs; in external-select builds the bench supplies the round-robin lane
    task automatic drive(input logic v, input logic [1:0] d,
                         input logic p0, input logic p1);
        valid_in = v;
        data_in  = d;
        pop0     = p0;
        pop1     = p1;
`ifdef DEMUX_SEL_EXT_EN
        sel_in   = m_sel;
`endif
    endtask

    // Advance one clock, update the model with the inputs seen at the edge
    task automatic tick();
        bit s, acc;
        @(posedge clk);
        if (!reset_L) begin
            q0.delete();
            q1.delete();
            m_sel = 1'b0;
        end else begin
            s   = cur_sel();
            acc = valid_in && ((s ? q1.size() : q0.size()) < DEPTH);
            if (pop0 && q0.size() != 0) void'(q0.pop_front());
            if (pop1 && q1.size() != 0) void'(q1.pop_front());
            if (acc) begin
                if (s) q1.push_back(data_in);
                else   q0.push_back(data_in);
                m_sel = ~s;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        tick();
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (obs_vec() !== 9'b1_0_00_0_0_00_0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", obs_vec(), 9'b1_0_00_0_0_00_0);
        end
    endtask

    task automatic test_interleave();
        logic [1:0] words [4] = '{2'b11, 2'b10, 2'b01, 2'b00};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, words[i], 1'b0, 1'b0);
            tick();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL interleave_step%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            if (i == 0) begin
                n_tests++;
                if (data_out0 !== 2'b11 || valid_out0 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL interleave_first_lat: got d0=%b v0=%b want 11/1", data_out0, valid_out0);
                end
            end
            if (i == 1) begin
                n_tests++;
                if (data_out1 !== 2'b10 || valid_out1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL interleave_second_lat: got d1=%b v1=%b want 10/1", data_out1, valid_out1);
                end
            end
        end
        // Drain both lanes and confirm ordering explicitly
        drive(1'b0, 2'b00, 1'b1, 1'b1);
        tick();
        n_tests++;
        if (data_out0 !== 2'b01 || data_out1 !== 2'b00) begin
            n_fail++;
            $display("FAIL interleave_order: got d0=%b d1=%b want 01/00", data_out0, data_out1);
        end
        tick();
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        n_tests++;
        if (obs_vec() !== 9'b1_0_00_0_0_00_0) begin
            n_fail++;
            $display("FAIL interleave_drained: got %b want %b", obs_vec(), 9'b1_0_00_0_0_00_0);
        end
    endtask

    task automatic test_gaps();
        logic       vpat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0] dpat [4] = '{2'b11, 2'b01, 2'b00, 2'b10};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(vpat[i], dpat[i], 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        n_tests++;
        if (data_out0 !== 2'b11 || data_out1 !== 2'b10 || valid_out0 !== 1'b1 || valid_out1 !== 1'b1) begin
            n_fail++;
            $display("FAIL gaps_no_skip: got d0=%b d1=%b want 11/10", data_out0, data_out1);
        end
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL gaps_model: got %b want %b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
            tick();
        end
        n_tests++;
        if (full0 !== 1'b1 || full1 !== 1'b1 || ready_out !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: got f0=%b f1=%b rdy=%b want 1/1/0", full0, full1, ready_out);
        end
        // Offered word must be refused while popping the full selected lane
        drive(1'b1, 2'b01, 1'b1, 1'b0);
        tick();
        n_tests++;
        if (full0 !== 1'b0 || ready_out !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL bp_release: got %b want %b", obs_vec(), exp_vec());
        end
        drive(1'b1, 2'b10, 1'b0, 1'b0);
        tick();
        n_tests++;
        if (full0 !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL bp_refill_lane0: got %b want %b", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        n_tests++;
        if (data_out0 !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_tail_word: got %b want 10", data_out0);
        end
    endtask

    task automatic test_corner();
        logic [1:0] w;
        do_reset();
        drive(1'b1, 2'b01, 1'b0, 1'b0);
        tick();
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        tick();
        n_tests++;
        if (valid_out1 !== 1'b0 || data_out1 !== 2'b00 || data_out0 !== 2'b01) begin
            n_fail++;
            $display("FAIL corner_pop_empty: got %b want %b", obs_vec(), exp_vec());
        end
        drive(1'b1, 2'b11, 1'b0, 1'b0); tick();
        drive(1'b1, 2'b10, 1'b0, 1'b0); tick();
        drive(1'b1, 2'b00, 1'b0, 1'b0); tick();
        // Lane 0 holds {01,10}; push 11 and pop in the same cycle
        drive(1'b1, 2'b11, 1'b1, 1'b0);
        tick();
        n_tests++;
        if (data_out0 !== 2'b10 || full0 !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL corner_push_pop: got %b want %b", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 6; i++) begin
            w = 2'($urandom_range(0, 3));
            drive(1'b1, w, 1'b1, 1'b1);
            tick();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL corner_wrap%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_midreset();
        do_reset();
        drive(1'b1, 2'b11, 1'b0, 1'b0); tick();
        drive(1'b1, 2'b01, 1'b0, 1'b0); tick();
        drive(1'b1, 2'b10, 1'b0, 1'b0); tick();
        reset_L = 1'b0;
        drive(1'b1, 2'b01, 1'b1, 1'b1);
        tick();
        reset_L = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        n_tests++;
        if (obs_vec() !== 9'b1_0_00_0_0_00_0) begin
            n_fail++;
            $display("FAIL midreset_flush: got %b want %b", obs_vec(), 9'b1_0_00_0_0_00_0);
        end
        drive(1'b1, 2'b10, 1'b0, 1'b0);
        tick();
        n_tests++;
        if (data_out0 !== 2'b10 || valid_out1 !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_sel0: got d0=%b v1=%b want 10/0", data_out0, valid_out1);
        end
`ifdef DEMUX_SEL_EXT_EN
        do_reset();
        valid_in = 1'b1; pop0 = 1'b0; pop1 = 1'b0;
        sel_in = 1'b1; data_in = 2'b11; tick();
        sel_in = 1'b1; data_in = 2'b01; tick();
        sel_in = 1'b0; data_in = 2'b10; tick();
        valid_in = 1'b0;
        n_tests++;
        if (data_out1 !== 2'b11 || data_out0 !== 2'b10 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL ext_sel_route: got %b want %b", obs_vec(), exp_vec());
        end
        pop1 = 1'b1; tick(); pop1 = 1'b0;
        n_tests++;
        if (data_out1 !== 2'b01) begin
            n_fail++;
            $display("FAIL ext_sel_order: got %b want 01", data_out1);
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset_L = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4);
`ifdef DEMUX_SEL_EXT_EN
            sel_in = 1'($urandom_range(0, 1));
`endif
            tick();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        reset_L = 1'b1;
    endtask

    initial begin
        reset_L = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        test_reset();
        test_interleave();
        test_gaps();
        test_backpressure();
        test_corner();
        test_midreset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_demux1a2_2b
